// File: rtl/zxtres_audio_pkg.sv
// Shared audio constants: default sample width, lock-loss timeout and the
// LRCLK channel encoding used by the I2S receive path.
package zxtres_audio_pkg;

    localparam int AUDIO_WIDTH_DEF   = 16;
    localparam int AUDIO_TIMEOUT_DEF = 1023;

    // Word-select encoding: LRCLK low carries the left channel.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    // True when a sampled word-select level denotes the left channel.
    function automatic logic is_left(input logic lr);
        return (chan_e'(lr) == CH_LEFT);
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchroniser for the I2S bundle {din, lrclk, bclk} into the clk domain.
// All three inputs go through identical flop chains so that their relative
// alignment is preserved; a registered rise strobe marks bclk rising edges
// and is presented together with the lrclk/din values seen at that edge.
module i2s_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic bclk_a,
    input  logic lrclk_a,
    input  logic din_a,
    output logic bclk_rise,
    output logic lrclk_sync,
    output logic din_sync
);

    // Bit 0 = bclk, bit 1 = lrclk, bit 2 = din
    logic [STAGES-1:0][2:0] chain_r;
    logic [2:0]             tail_s;
    logic                   bclk_prev_r;
    logic                   rise_r;
    logic                   lrclk_r;
    logic                   din_r;

    assign tail_s = chain_r[STAGES-1];

    // Identical multi-stage chains for the three asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_r <= '0;
        end else begin
            chain_r[0] <= {din_a, lrclk_a, bclk_a};
            for (int i = 1; i < STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
        end
    end

    // Rise detection on synchronised bclk, with lrclk/din registered alongside
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_prev_r <= 1'b0;
            rise_r      <= 1'b0;
            lrclk_r     <= 1'b0;
            din_r       <= 1'b0;
        end else begin
            bclk_prev_r <= tail_s[0];
            rise_r      <= tail_s[0] & ~bclk_prev_r;
            lrclk_r     <= tail_s[1];
            din_r       <= tail_s[2];
        end
    end

    assign bclk_rise  = rise_r;
    assign lrclk_sync = lrclk_r;
    assign din_sync   = din_r;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises MSB-first slots, pairs a left word with the
// following right word and presents both with a one-clk sample_valid pulse.
// Word alignment (locked) is acquired on the first slot boundary and lost
// after TIMEOUT clk cycles without a bclk rising edge.
module i2s_rx
    import zxtres_audio_pkg::*;
#(
    parameter int WIDTH       = AUDIO_WIDTH_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = AUDIO_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i2s_bclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_din,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             sample_valid,
    output logic             frame_err,
    output logic             locked
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    logic             rise_s;
    logic             lr_s;
    logic             din_s;
    logic             boundary_s;

    logic [CW-1:0]    cnt_r,     cnt_n;
    logic [WIDTH-1:0] word_r,    word_n;
    logic [WIDTH-1:0] hold_r,    hold_n;
    logic             left_ok_r, left_ok_n;
    logic             locked_r,  locked_n;
    logic             prev_lr_r, prev_lr_n;
    logic             have_prev_r, have_prev_n;
    logic [TW-1:0]    to_cnt_r,  to_cnt_n;
    logic             pend_s;
    logic             ferr_s;

    logic [WIDTH-1:0] left_r;
    logic [WIDTH-1:0] right_r;
    logic             sample_valid_r;
    logic             frame_err_r;

    i2s_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .bclk_a     (i2s_bclk),
        .lrclk_a    (i2s_lrclk),
        .din_a      (i2s_din),
        .bclk_rise  (rise_s),
        .lrclk_sync (lr_s),
        .din_sync   (din_s)
    );

    // The first rise after reset or lock loss only records lrclk, so a
    // partially observed slot can never be mistaken for a boundary.
    assign boundary_s = rise_s & have_prev_r & (lr_s != prev_lr_r);

    // Slot tracking, word assembly, pairing and lock/timeout next-state
    always_comb begin
        cnt_n       = cnt_r;
        word_n      = word_r;
        hold_n      = hold_r;
        left_ok_n   = left_ok_r;
        locked_n    = locked_r;
        prev_lr_n   = prev_lr_r;
        have_prev_n = have_prev_r;
        to_cnt_n    = to_cnt_r;
        pend_s      = 1'b0;
        ferr_s      = 1'b0;

        if (rise_s) begin
            to_cnt_n    = '0;
            prev_lr_n   = lr_s;
            have_prev_n = 1'b1;
            if (boundary_s) begin
                // Boundary bit is the previous slot's tail: never shifted.
                // A short slot (including one ending on bit WIDTH-1) is an error.
                if (locked_r && (cnt_r < CNT_FULL)) begin
                    ferr_s = 1'b1;
                    if (is_left(prev_lr_r)) begin
                        left_ok_n = 1'b0;
                    end else begin
                        left_ok_n = left_ok_r;
                    end
                end else begin
                    ferr_s = 1'b0;
                end
                locked_n = 1'b1;
                cnt_n    = '0;
                word_n   = '0;
            end else if (locked_r && (cnt_r < CNT_FULL)) begin
                word_n = {word_r[WIDTH-2:0], din_s};
                cnt_n  = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    if (is_left(lr_s)) begin
                        hold_n    = word_n;
                        left_ok_n = 1'b1;
                    end else if (left_ok_r) begin
                        pend_s    = 1'b1;
                        left_ok_n = 1'b0;
                    end else begin
                        // Right word without a preceding left word: dropped
                        left_ok_n = 1'b0;
                    end
                end else begin
                    left_ok_n = left_ok_r;
                end
            end else begin
                // Unlocked, or slot already saturated: extra bits ignored
                cnt_n = cnt_r;
            end
        end else if (to_cnt_r == TO_MAX) begin
            locked_n    = 1'b0;
            left_ok_n   = 1'b0;
            cnt_n       = '0;
            word_n      = '0;
            have_prev_n = 1'b0;
        end else begin
            to_cnt_n = to_cnt_r + TO_ONE;
        end
    end

    // Internal state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r       <= '0;
            word_r      <= '0;
            hold_r      <= '0;
            left_ok_r   <= 1'b0;
            locked_r    <= 1'b0;
            prev_lr_r   <= 1'b0;
            have_prev_r <= 1'b0;
            to_cnt_r    <= '0;
        end else begin
            cnt_r       <= cnt_n;
            word_r      <= word_n;
            hold_r      <= hold_n;
            left_ok_r   <= left_ok_n;
            locked_r    <= locked_n;
            prev_lr_r   <= prev_lr_n;
            have_prev_r <= have_prev_n;
            to_cnt_r    <= to_cnt_n;
        end
    end

    // Registered outputs: the stereo pair updates only together with sample_valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_r         <= '0;
            right_r        <= '0;
            sample_valid_r <= 1'b0;
            frame_err_r    <= 1'b0;
        end else begin
            sample_valid_r <= pend_s;
            frame_err_r    <= ferr_s;
            if (pend_s) begin
                left_r  <= hold_r;
                right_r <= word_n;
            end else begin
                left_r  <= left_r;
                right_r <= right_r;
            end
        end
    end

    assign left         = left_r;
    assign right        = right_r;
    assign sample_valid = sample_valid_r;
    assign frame_err    = frame_err_r;
    assign locked       = locked_r;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: directed I2S frames, scoreboard of expected output
// events (sample pairs and frame errors) checked by an independent monitor.
// A slot of N data bits is driven as one delay bit (tail of the previous
// slot) followed by N bits MSB first, all with the slot's lrclk level.
module tb_i2s_rx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i2s_bclk = 1'b0;
    logic         i2s_lrclk = 1'b0;
    logic         i2s_din = 1'b0;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         sample_valid;
    logic         frame_err;
    logic         locked;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic         is_ferr;
        logic [W-1:0] l;
        logic [W-1:0] r;
    } exp_t;

    exp_t exp_q[$];
    logic last_bit = 1'b0;

    i2s_rx #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .TIMEOUT     (1023)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_din      (i2s_din),
        .left         (left),
        .right        (right),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_valid(input logic [W-1:0] l, input logic [W-1:0] r);
        exp_t e;
        e.is_ferr = 1'b0;
        e.l = l;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic push_ferr();
        exp_t e;
        e.is_ferr = 1'b1;
        e.l = '0;
        e.r = '0;
        exp_q.push_back(e);
    endtask

    // One bclk period = 8 clk: low half then high half
    task automatic send_bit(input logic lr, input logic d);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_din   = d;
        repeat (4) @(posedge clk);
        #1;
        i2s_bclk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] data, input int nbits);
        send_bit(lr, last_bit);
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit(lr, data[i]);
        end
        last_bit = data[0];
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
        send_slot(1'b0, l, nbits);
        send_slot(1'b1, r, nbits);
    endtask

    // Monitor: every output pulse is matched against the head of the queue
    initial begin : monitor
        exp_t e;
        logic prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && (sample_valid || frame_err)) begin
                checks++;
                if (prev_pulse) begin
                    failures++;
                    $display("FAIL sb_back_to_back sv=%0b fe=%0b expected a gap cycle", sample_valid, frame_err);
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected sv=%0b fe=%0b left=%h right=%h expected no event",
                             sample_valid, frame_err, left, right);
                end else begin
                    e = exp_q.pop_front();
                    if (sample_valid && frame_err) begin
                        failures++;
                        $display("FAIL sb_both sv=1 fe=1 expected only one");
                    end else if (sample_valid) begin
                        if (e.is_ferr || left !== e.l || right !== e.r) begin
                            failures++;
                            $display("FAIL sb_valid got left=%h right=%h expected ferr=%0b left=%h right=%h",
                                     left, right, e.is_ferr, e.l, e.r);
                        end
                    end else if (!e.is_ferr) begin
                        failures++;
                        $display("FAIL sb_ferr got frame_err expected sample left=%h right=%h", e.l, e.r);
                    end
                end
            end
            prev_pulse = reset_n && (sample_valid || frame_err);
        end
    end

    initial begin : stimulus
        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_left", 32'(left), 32'h0);
        chk("rst_right", 32'(right), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_pulses", 32'({sample_valid, frame_err}), 32'h0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Start mid left slot: no lock until the first boundary
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1);
        chk("lock_before_boundary", 32'(locked), 32'h0);
        send_slot(1'b1, 32'h0000_ABCD, 16);      // locks; right without left dropped
        chk("lock_after_boundary", 32'(locked), 32'h1);

        // Normal frames
        push_valid(16'h1234, 16'hABCD);
        send_frame(32'h1234, 32'hABCD, 16);
        push_valid(16'h1234, 16'hABCD);
        send_frame(32'h1234, 32'hABCD, 16);
        push_valid(16'h0000, 16'hFFFF);
        send_frame(32'h0000, 32'hFFFF, 16);
        push_valid(16'hA5A5, 16'h5A5A);
        send_frame(32'hA5A5, 32'h5A5A, 16);

        // Wide 32-bit slots: upper 16 bits captured, padding ignored
        push_valid(16'h8001, 16'h7FFE);
        send_frame(32'h8001_FFFF, 32'h7FFE_0000, 32);

        // Short 12-bit left slot: one frame_err, right word dropped
        push_ferr();
        send_slot(1'b0, 32'h0000_0FFF, 12);
        send_slot(1'b1, 32'h0000_1111, 16);
        repeat (10) @(posedge clk);
        #1;
        chk("short_hold_left", 32'(left), 32'h8001);
        chk("short_hold_right", 32'(right), 32'h7FFE);

        // Boundary on the rise that would carry bit WIDTH-1: error, no commit
        push_ferr();
        send_slot(1'b0, 32'h0000_7FFF, 15);
        send_slot(1'b1, 32'h0000_2222, 16);
        repeat (10) @(posedge clk);
        #1;
        chk("race_hold_left", 32'(left), 32'h8001);
        chk("race_hold_right", 32'(right), 32'h7FFE);

        push_valid(16'h0F0F, 16'hF0F0);
        send_frame(32'h0F0F, 32'hF0F0, 16);

        // Timeout: bclk idle well past TIMEOUT + 1 clk
        i2s_bclk = 1'b0;
        repeat (1100) @(posedge clk);
        #1;
        chk("timeout_unlocked", 32'(locked), 32'h0);
        chk("timeout_hold_left", 32'(left), 32'h0F0F);
        chk("timeout_hold_right", 32'(right), 32'hF0F0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        chk("timeout_no_early_lock", 32'(locked), 32'h0);
        push_valid(16'h3C3C, 16'hC3C3);
        send_slot(1'b0, 32'h3C3C, 16);
        chk("relock", 32'(locked), 32'h1);
        send_slot(1'b1, 32'hC3C3, 16);

        // Reset asserted mid-word clears outputs immediately
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst_left", 32'(left), 32'h0);
        chk("midrst_right", 32'(right), 32'h0);
        chk("midrst_locked", 32'(locked), 32'h0);
        chk("midrst_pulses", 32'({sample_valid, frame_err}), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1);
        chk("postrst_unlocked", 32'(locked), 32'h0);
        send_slot(1'b1, 32'h9999, 16);
        chk("postrst_locked", 32'(locked), 32'h1);
        push_valid(16'h6666, 16'h9999);
        send_frame(32'h6666, 32'h9999, 16);

        // Flush and confirm every expected event was seen
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("sb_all_events_seen", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
